// File: rtl/irq_source_dev.sv
// Memory-mapped interrupt source: programmable countdown that raises irq until the CPU ACKs it.
// Latency: reads are combinational; register writes land on the next posedge; irq is registered.
// Backpressure: none. Every bus access completes in the cycle it is presented.
module irq_source_dev #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F20,
    parameter int unsigned MISS_W    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteen,
    output logic [31:0] rdata,
    output logic        irq
);

    // Word offsets inside the 16-byte register window.
    localparam logic [1:0] OFF_STAT   = 2'd0;
    localparam logic [1:0] OFF_PERIOD = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_COUNT  = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Architectural state.
    state_t              r_state;
    logic [31:0]         r_period;
    logic [31:0]         r_count;
    logic                r_en;
    logic                r_mode;
    logic                r_pending;
    logic [MISS_W-1:0]   r_missed;

    // Bus decode.
    logic                w_hit;
    logic                w_wr;
    logic [1:0]          w_off;
    logic                w_ack;
    logic                w_period_wr;
    logic                w_ctrl_wr;
    logic                w_ctrl_en;
    logic                w_ctrl_mode;

    // Next-state values.
    state_t              w_state_nxt;
    logic [31:0]         w_count_nxt;
    logic                w_en_nxt;
    logic                w_mode_nxt;
    logic                w_expire;
    logic [31:0]         w_period_nxt;
    logic                w_pending_nxt;
    logic [MISS_W-1:0]   w_missed_nxt;
    logic [31:0]         w_stat;

    // Byte-lane and bit-field bits that never influence any state.
    logic                w_unused;

    assign w_hit       = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_wr        = w_hit & (|byteen);
    assign w_off       = addr[3:2];
    assign w_ack       = w_wr & (w_off == OFF_STAT);
    assign w_period_wr = w_wr & (w_off == OFF_PERIOD);
    // CTRL lives entirely in byte 0, so only that lane makes a CTRL write.
    assign w_ctrl_wr   = w_wr & (w_off == OFF_CTRL) & byteen[0];
    assign w_ctrl_en   = wdata[0];
    assign w_ctrl_mode = wdata[1];
    assign w_unused    = &{1'b0, addr[1:0]};

    assign irq = r_pending;

    // Timer FSM: load on enable, count down, expire at zero, reload or stop by MODE.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_en_nxt    = r_en;
        w_mode_nxt  = r_mode;
        w_expire    = 1'b0;

        if (w_ctrl_wr) begin
            w_en_nxt   = w_ctrl_en;
            w_mode_nxt = w_ctrl_mode;
        end

        case (r_state)
            ST_IDLE: begin
                // Only a rising EN starts a countdown; COUNT otherwise holds.
                if (w_ctrl_wr && w_ctrl_en && !r_en) begin
                    w_count_nxt = r_period;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_ctrl_wr && !w_ctrl_en) begin
                    // Disable wins over expiry; COUNT freezes where it is.
                    w_state_nxt = ST_IDLE;
                end else if (r_count != 32'd0) begin
                    w_count_nxt = r_count - 32'd1;
                end else begin
                    // Expiry uses the MODE in force before this edge; a
                    // concurrent PERIOD write is only seen at a later load.
                    w_expire = 1'b1;
                    if (r_mode) begin
                        w_count_nxt = r_period;
                    end else begin
                        w_en_nxt    = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pending/missed bookkeeping: a fresh expiry beats a same-edge ACK.
    always_comb begin
        w_pending_nxt = r_pending;
        w_missed_nxt  = r_missed;
        if (w_expire) begin
            w_pending_nxt = 1'b1;
            if (r_pending && !w_ack && (r_missed != {MISS_W{1'b1}})) begin
                w_missed_nxt = r_missed + MISS_W'(1);
            end
        end else if (w_ack) begin
            w_pending_nxt = 1'b0;
        end
    end

    // PERIOD byte-lane merge.
    always_comb begin
        w_period_nxt = r_period;
        if (w_period_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (byteen[b]) begin
                    w_period_nxt[8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
    end

    // Combinational read mux; anything outside the window reads as zero.
    always_comb begin
        w_stat                   = '0;
        w_stat[31 -: MISS_W]     = r_missed;
        w_stat[0]                = r_pending;
        rdata                    = '0;
        if (w_hit) begin
            case (w_off)
                OFF_STAT:   rdata = w_stat;
                OFF_PERIOD: rdata = r_period;
                OFF_CTRL:   rdata = {30'd0, r_mode, r_en};
                OFF_COUNT:  rdata = r_count;
                default:    rdata = '0;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_period  <= '0;
            r_count   <= '0;
            r_en      <= 1'b0;
            r_mode    <= 1'b0;
            r_pending <= 1'b0;
            r_missed  <= '0;
        end else begin
            r_period  <= w_period_nxt;
            r_count   <= w_count_nxt;
            r_en      <= w_en_nxt;
            r_mode    <= w_mode_nxt;
            r_pending <= w_pending_nxt;
            r_missed  <= w_missed_nxt;
        end
    end

endmodule

// File: tb/tb_irq_source_dev.sv
// Bench for irq_source_dev: directed vector table, saturation run, randomized traffic vs reference model.
// Inputs driven at negedge, outputs sampled 2 time units later (before the next posedge).
// No backpressure involved; every cycle is one bus access.
module tb_irq_source_dev;

    localparam logic [31:0] B    = 32'h0000_7F20;
    localparam logic [31:0] STAT = B + 32'h0;
    localparam logic [31:0] PER  = B + 32'h4;
    localparam logic [31:0] CTRL = B + 32'h8;
    localparam logic [31:0] CNT  = B + 32'hC;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    logic [31:0] rdata;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    irq_source_dev dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .wdata  (wdata),
        .byteen (byteen),
        .rdata  (rdata),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        bit          chk;
        logic [31:0] er;
        bit          ei;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit rst, logic [31:0] a, logic [31:0] wd, logic [3:0] be,
                                bit chk, logic [31:0] er, bit ei);
        vec_t v;
        v.rst = rst; v.a = a; v.wd = wd; v.be = be; v.chk = chk; v.er = er; v.ei = ei;
        vecs.push_back(v);
    endfunction

    function automatic void rd(logic [31:0] a, logic [31:0] er, bit ei);
        add(1'b0, a, 32'h0, 4'h0, 1'b1, er, ei);
    endfunction

    function automatic void wr(logic [31:0] a, logic [31:0] wd, logic [3:0] be, logic [31:0] er, bit ei);
        add(1'b0, a, wd, be, 1'b1, er, ei);
    endfunction

    task automatic cyc(input bit r, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        @(negedge clk);
        reset  = r;
        addr   = a;
        wdata  = wd;
        byteen = be;
        #2;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: register file and timer described directly from the register rules.
    logic [31:0] m_per;
    logic [31:0] m_cnt;
    bit          m_run;
    bit          m_mode;
    bit          m_pend;
    int          m_miss;

    function automatic logic [31:0] model_rdata(logic [31:0] a);
        logic [31:0] r;
        r = 32'h0;
        if (a[31:4] == B[31:4]) begin
            case (a[3:2])
                2'd0: r = (32'(m_miss) << 16) | {31'd0, m_pend};
                2'd1: r = m_per;
                2'd2: r = {30'd0, m_mode, m_run};
                default: r = m_cnt;
            endcase
        end
        return r;
    endfunction

    task automatic model_step(input bit rst, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        bit          hit;
        bit          ack;
        bit          ctw;
        bit          pw;
        bit          fired;
        bit          old_mode;
        logic [31:0] old_per;
        if (rst) begin
            m_per = 0; m_cnt = 0; m_run = 0; m_mode = 0; m_pend = 0; m_miss = 0;
            return;
        end
        hit      = (a[31:4] == B[31:4]);
        ack      = hit && (be != 0) && (a[3:2] == 2'd0);
        pw       = hit && (be != 0) && (a[3:2] == 2'd1);
        ctw      = hit && be[0] && (a[3:2] == 2'd2);
        fired    = 0;
        old_mode = m_mode;
        old_per  = m_per;
        if (!m_run) begin
            if (ctw) begin
                m_mode = wd[1];
                if (wd[0]) begin
                    m_run = 1;
                    m_cnt = old_per;
                end
            end
        end else if (ctw && !wd[0]) begin
            m_run  = 0;
            m_mode = wd[1];
        end else begin
            if (ctw) m_mode = wd[1];
            if (m_cnt == 0) begin
                fired = 1;
                if (old_mode) m_cnt = old_per;
                else          m_run = 0;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
        if (fired) begin
            if (m_pend && !ack && m_miss < 65535) m_miss++;
            m_pend = 1;
        end else if (ack) begin
            m_pend = 0;
        end
        if (pw) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) m_per[8*k +: 8] = wd[8*k +: 8];
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        addr   = 32'h0;
        wdata  = 32'h0;
        byteen = 4'h0;

        // Reset and read-back.
        add(1'b1, STAT, 0, 4'h0, 1'b0, 0, 1'b0);
        rd(STAT, 0, 0); rd(PER, 0, 0); rd(CTRL, 0, 0); rd(CNT, 0, 0);
        // One-shot, PERIOD=3: irq rises after edge t+4.
        wr(PER, 3, 4'hF, 0, 0);
        rd(PER, 3, 0);
        wr(CTRL, 1, 4'h1, 0, 0);
        rd(CNT, 3, 0); rd(CNT, 2, 0); rd(CNT, 1, 0); rd(CNT, 0, 0);
        rd(CTRL, 0, 1); rd(CNT, 0, 1); rd(STAT, 1, 1);
        // Byte-store ACK, wdata ignored.
        wr(STAT, 32'hFFFF_FFFF, 4'h1, 1, 1);
        rd(STAT, 0, 0);
        // Periodic PERIOD=2, unacknowledged: expiries every 3 cycles.
        wr(PER, 2, 4'hF, 3, 0);
        wr(CTRL, 3, 4'h1, 0, 0);
        rd(STAT, 0, 0); rd(STAT, 0, 0); rd(STAT, 0, 0);
        rd(STAT, 1, 1); rd(STAT, 1, 1); rd(STAT, 1, 1);
        rd(STAT, 32'h0001_0001, 1); rd(STAT, 32'h0001_0001, 1); rd(STAT, 32'h0001_0001, 1);
        rd(STAT, 32'h0002_0001, 1);
        // ACK on the expiry edge: pending stays, missed unchanged.
        rd(CNT, 1, 1);
        wr(STAT, 0, 4'h1, 32'h0002_0001, 1);
        rd(STAT, 32'h0002_0001, 1);
        // Plain ACK, then the next expiry re-raises.
        wr(STAT, 0, 4'h1, 32'h0002_0001, 1);
        rd(STAT, 32'h0002_0000, 0);
        rd(STAT, 32'h0002_0001, 1);
        wr(CTRL, 0, 4'h1, 3, 1);
        rd(CNT, 1, 1); rd(CTRL, 0, 1);
        add(1'b1, STAT, 0, 4'h0, 1'b1, 32'h0002_0001, 1'b1);
        rd(STAT, 0, 0);
        // Disable mid-run freezes COUNT at 3.
        wr(PER, 5, 4'hF, 0, 0);
        wr(CTRL, 1, 4'h1, 0, 0);
        rd(CNT, 5, 0); rd(CNT, 4, 0);
        wr(CTRL, 0, 4'h1, 1, 0);
        rd(CNT, 3, 0); rd(CNT, 3, 0);
        // Accesses just outside the window.
        wr(B + 32'h10, 32'hFFFF_FFFF, 4'hF, 0, 0);
        wr(B + 32'h18, 1, 4'h1, 0, 0);
        rd(CNT, 3, 0); rd(CTRL, 0, 0); rd(PER, 5, 0);
        // PERIOD byte merge; low address bits ignored.
        wr(PER, 32'hAABB_CCDD, 4'b0101, 5, 0);
        rd(PER, 32'h00BB_00DD, 0);
        rd(B + 32'h7, 32'h00BB_00DD, 0);
        // CTRL write without lane 0 and COUNT write are both ignored.
        wr(CTRL, 1, 4'b0010, 0, 0);
        rd(CTRL, 0, 0); rd(CNT, 3, 0);
        wr(CNT, 32'hFFFF, 4'hF, 3, 0);
        rd(CNT, 3, 0);
        // Reset mid-run.
        wr(PER, 4, 4'hF, 32'h00BB_00DD, 0);
        wr(CTRL, 3, 4'h1, 0, 0);
        rd(CNT, 4, 0);
        add(1'b1, CNT, 0, 4'h0, 1'b1, 3, 1'b0);
        rd(CNT, 0, 0); rd(PER, 0, 0); rd(CTRL, 0, 0); rd(STAT, 0, 0);
        // PERIOD=0 periodic: expiry every cycle.
        wr(CTRL, 3, 4'h1, 0, 0);
        rd(STAT, 0, 0);
        rd(STAT, 1, 1);
        rd(STAT, 32'h0001_0001, 1);
        wr(STAT, 0, 4'h1, 32'h0002_0001, 1);
        wr(CTRL, 0, 4'h1, 3, 1);
        rd(STAT, 32'h0002_0001, 1);
        add(1'b1, STAT, 0, 4'h0, 1'b1, 32'h0002_0001, 1'b1);
        rd(STAT, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rst, vecs[i].a, vecs[i].wd, vecs[i].be);
            if (vecs[i].chk) begin
                check($sformatf("vec%0d rdata", i), rdata, vecs[i].er);
                check($sformatf("vec%0d irq", i), {31'd0, irq}, {31'd0, vecs[i].ei});
            end
        end

        // Missed counter saturates at all-ones and never wraps.
        cyc(1'b0, CTRL, 3, 4'h1);
        for (int i = 0; i < 65600; i++) cyc(1'b0, STAT, 0, 4'h0);
        check("sat stat", rdata, 32'hFFFF_0001);
        check("sat irq", {31'd0, irq}, 32'd1);
        cyc(1'b0, STAT, 0, 4'h0);
        check("sat hold", rdata, 32'hFFFF_0001);
        cyc(1'b0, CTRL, 0, 4'h1);
        cyc(1'b1, STAT, 0, 4'h0);

        // Randomized traffic against the reference model.
        model_step(1'b1, 0, 0, 4'h0);
        for (int n = 0; n < 2500; n++) begin
            bit          r_rst;
            logic [31:0] r_a;
            logic [31:0] r_wd;
            logic [3:0]  r_be;
            r_rst = ($urandom_range(0, 99) < 2);
            r_a   = B + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) r_a = r_a ^ (32'h10 << $urandom_range(0, 20));
            r_be  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            r_wd  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 7));
            cyc(r_rst, r_a, r_wd, r_be);
            check($sformatf("rand%0d rdata a=%h", n, r_a), rdata, model_rdata(r_a));
            check($sformatf("rand%0d irq", n), {31'd0, irq}, {31'd0, m_pend});
            model_step(r_rst, r_a, r_wd, r_be);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
